saw_period_meter: RTL and testbench
===================================

SAW_PERIOD_METER -- requirements
Module: saw_period_meter

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 24: sample width in bits, two's complement.
REQ-002 SHALL have parameter PERIOD_W, default 26: width of the period result and of the internal counter.
REQ-003 SHALL have parameter WRAP_THRESH, default 24'h0FFFFF: minimum downward step that counts as a wrap.
REQ-004 SHALL have port clk  input  1  single system clock (48 MHz); all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port en  input  1  meter enable; low forces IDLE.
REQ-007 SHALL have port sample  input  SAMPLE_W  signed sawtooth sample stream.
REQ-008 SHALL have port sample_valid  input  1  qualifies sample; only qualified samples are processed.
REQ-009 SHALL have port period  output  PERIOD_W  last measured period, in the same units as the generator period setting.
REQ-010 SHALL have port period_valid  output  1  one-cycle pulse when period updates.
REQ-011 SHALL have port locked  output  1  high while two consecutive measurements match.
REQ-012 SHALL have port overflow  output  1  one-cycle pulse on counter saturation.

Function
REQ-013 SHALL implement states IDLE, SEEK, MEASURE.
REQ-014 SHALL go IDLE->SEEK on the first cycle with en high; any state ->IDLE on the next cycle whenever en is low.
REQ-015 SHALL register the previous qualified sample (prev) plus a prev_ok flag; prev_ok clears in IDLE, and the first qualified sample after IDLE never produces a wrap.
REQ-016 SHALL declare a wrap on a qualified sample when prev_ok is set and (prev - sample), computed at SAMPLE_W+1 bits signed, is strictly greater than WRAP_THRESH.
REQ-017 SHALL go SEEK->MEASURE on a wrap and load count = 1.
REQ-018 SHALL, in MEASURE, increment count by 1 on each qualified non-wrap sample and hold it when sample_valid is low.
REQ-019 SHALL, on a wrap in MEASURE, load period = count - 1, pulse period_valid the following cycle (1-cycle latency from the wrap sample), reload count = 1, and stay in MEASURE.
REQ-020 SHALL, when count equals 2^PERIOD_W - 1 and a non-wrap qualified sample arrives, pulse overflow, clear locked, go to SEEK, and leave period unchanged.
REQ-021 SHALL set locked on a period_valid whose new value equals the previous published value, and clear it on a period_valid with a differing value.
REQ-022 SHALL give wrap priority over overflow when both occur on the same sample.
REQ-023 SHALL hold period and locked in SEEK, and SHALL clear locked and count on entry to IDLE while period keeps its last value.
REQ-024 SHALL never assert period_valid and overflow in the same cycle.

Reset
REQ-025 SHALL, while rst is high, force state IDLE, count 0, prev 0, prev_ok 0, period 0, period_valid 0, locked 0, overflow 0.
REQ-026 SHALL, on rst asserted mid-measurement, abort immediately with no pulse emitted, and SHALL first leave IDLE on the first clk edge after rst deasserts with en high.

Structure
REQ-027 SHALL take SAMPLE_W, PERIOD_W and WRAP_THRESH defaults from the shared package audio_pkg, together with the state enumeration constants.
REQ-028 SHALL place the prev register and the wrap compare in one sub-module, saw_wrap_detect; counter, FSM and lock logic stay in the top.

Verification
REQ-029 SHALL cover: ideal saw, period setting 99, amplitude 24'hFFFFF, sample_valid always high -> first period_valid carries 99, locked rises on the second pulse, pulses 100 cycles apart.
REQ-030 SHALL cover: same saw with sample_valid high every other cycle -> period 99 is still reported, pulses 200 cycles apart.
REQ-031 SHALL cover: period setting switched from 99 to 49 mid-stream -> one transitional value is reported, locked drops, then 49 is reported twice and locked rises again.
REQ-032 SHALL cover: constant sample 0 with PERIOD_W overridden to 8 after one wrap -> overflow pulses after 255 counted samples, locked=0, state SEEK, period unchanged.
REQ-033 SHALL cover: en dropped 10 samples into MEASURE and re-raised -> no period_valid until two new wraps, locked=0.
REQ-034 SHALL cover: rst asserted asynchronously between clk edges during MEASURE -> all outputs are 0 before the next edge, and none pulse after release until a full period is seen.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared definitions for the audio measurement blocks.
//   SAMPLE_W_DEF    : default sample width (two's complement)
//   PERIOD_W_DEF    : default width of period results and counters
//   WRAP_THRESH_DEF : default minimum downward step recognised as a saw wrap
//   meter_state_e   : state encoding of the saw period meter
package audio_pkg;

    localparam int          SAMPLE_W_DEF    = 24;
    localparam int          PERIOD_W_DEF    = 26;
    localparam logic [23:0] WRAP_THRESH_DEF = 24'h0FFFFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEEK    = 2'd1,
        ST_MEASURE = 2'd2
    } meter_state_e;

endpackage

// File: rtl/saw_wrap_detect.sv
// Sawtooth wrap detector: remembers the previous qualified sample and flags
// a wrap when the current qualified sample falls below it by more than
// WRAP_THRESH.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   clr           : forget the stored sample (meter inactive)
//   sample_valid  : qualifies sample
//   sample        : signed sawtooth sample
//   wrap          : combinational, high for a qualified sample that wraps
module saw_wrap_detect
    import audio_pkg::*;
#(
    parameter int                  SAMPLE_W    = SAMPLE_W_DEF,
    parameter logic [SAMPLE_W-1:0] WRAP_THRESH = SAMPLE_W'(WRAP_THRESH_DEF)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       sample_valid,
    input  logic signed [SAMPLE_W-1:0] sample,
    output logic                       wrap
);

    // Threshold zero-extended so the compare stays a positive signed value.
    localparam logic signed [SAMPLE_W:0] THRESH_EXT = $signed({1'b0, WRAP_THRESH});

    logic signed [SAMPLE_W-1:0] prev_q, prev_d;
    logic                       prev_ok_q, prev_ok_d;
    logic signed [SAMPLE_W:0]   diff;

    always_comb begin
        prev_d    = prev_q;
        prev_ok_d = prev_ok_q;
        if (clr) begin
            prev_ok_d = 1'b0;
        end else if (sample_valid) begin
            prev_d    = sample;
            prev_ok_d = 1'b1;
        end
    end

    // One extra bit so a full-scale positive-to-negative drop cannot overflow.
    always_comb begin
        diff = $signed({prev_q[SAMPLE_W-1], prev_q}) - $signed({sample[SAMPLE_W-1], sample});
        wrap = sample_valid && !clr && prev_ok_q && (diff > THRESH_EXT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q    <= '0;
            prev_ok_q <= 1'b0;
        end else begin
            prev_q    <= prev_d;
            prev_ok_q <= prev_ok_d;
        end
    end

endmodule

// File: rtl/saw_period_meter.sv
// Sawtooth period meter: counts qualified samples between successive wraps
// of a sawtooth stream and publishes the period (samples per cycle minus
// one, matching the generator's period setting).
// Ports:
//   clk, rst      : 48 MHz clock, asynchronous active-high reset
//   en            : meter enable, low returns the meter to IDLE
//   sample        : signed sawtooth sample
//   sample_valid  : qualifies sample
//   period        : last published period
//   period_valid  : one-cycle pulse when period is updated
//   locked        : high while the last two published periods matched
//   overflow      : one-cycle pulse when the sample counter saturates
module saw_period_meter
    import audio_pkg::*;
#(
    parameter int                  SAMPLE_W    = SAMPLE_W_DEF,
    parameter int                  PERIOD_W    = PERIOD_W_DEF,
    parameter logic [SAMPLE_W-1:0] WRAP_THRESH = SAMPLE_W'(WRAP_THRESH_DEF)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic signed [SAMPLE_W-1:0] sample,
    input  logic                       sample_valid,
    output logic [PERIOD_W-1:0]        period,
    output logic                       period_valid,
    output logic                       locked,
    output logic                       overflow
);

    localparam logic [PERIOD_W-1:0] COUNT_MAX = '1;
    localparam logic [PERIOD_W-1:0] COUNT_ONE = PERIOD_W'(1);

    meter_state_e        state_q, state_d;
    logic [PERIOD_W-1:0] count_q, count_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                period_valid_q, period_valid_d;
    logic                locked_q, locked_d;
    logic                overflow_q, overflow_d;
    // Set once a period has been published in the current session, so the
    // first measurement after IDLE/overflow never compares against stale data.
    logic                pub_ok_q, pub_ok_d;

    logic                active;
    logic                clr_prev;
    logic                qual;
    logic                wrap;
    logic [PERIOD_W-1:0] measured;

    // A sample seen in the cycle en drops is ignored: the meter is leaving.
    assign active   = en && (state_q != ST_IDLE);
    assign clr_prev = !active;
    assign qual     = active && sample_valid;
    assign measured = count_q - COUNT_ONE;

    saw_wrap_detect #(
        .SAMPLE_W    (SAMPLE_W),
        .WRAP_THRESH (WRAP_THRESH)
    ) u_wrap (
        .clk          (clk),
        .rst          (rst),
        .clr          (clr_prev),
        .sample_valid (qual),
        .sample       (sample),
        .wrap         (wrap)
    );

    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        period_d       = period_q;
        period_valid_d = 1'b0;
        locked_d       = locked_q;
        overflow_d     = 1'b0;
        pub_ok_d       = pub_ok_q;

        if (!en) begin
            state_d  = ST_IDLE;
            count_d  = '0;
            locked_d = 1'b0;
            pub_ok_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d  = ST_SEEK;
                    count_d  = '0;
                    locked_d = 1'b0;
                    pub_ok_d = 1'b0;
                end
                ST_SEEK: begin
                    if (wrap) begin
                        state_d = ST_MEASURE;
                        count_d = COUNT_ONE;
                    end
                end
                ST_MEASURE: begin
                    // Wrap is tested first so it wins over a saturated count.
                    if (wrap) begin
                        period_d       = measured;
                        period_valid_d = 1'b1;
                        count_d        = COUNT_ONE;
                        locked_d       = pub_ok_q && (measured == period_q);
                        pub_ok_d       = 1'b1;
                    end else if (qual) begin
                        if (count_q == COUNT_MAX) begin
                            overflow_d = 1'b1;
                            locked_d   = 1'b0;
                            pub_ok_d   = 1'b0;
                            count_d    = '0;
                            state_d    = ST_SEEK;
                        end else begin
                            count_d = count_q + COUNT_ONE;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            count_q        <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            overflow_q     <= 1'b0;
            pub_ok_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            locked_q       <= locked_d;
            overflow_q     <= overflow_d;
            pub_ok_q       <= pub_ok_d;
        end
    end

    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign locked       = locked_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_saw_period_meter.sv
// Scoreboard bench for saw_period_meter: the stimulus pushes each expected
// pulse (kind, value, locked, cycle) when it drives the sample that causes
// it; per-DUT monitors pop and compare whenever a pulse appears.
module tb_saw_period_meter;
    import audio_pkg::*;

    localparam longint AMP = 64'h00000000000FFFFF;

    logic                clk = 1'b0;
    logic                rst;
    logic                en;
    logic                sample_valid;
    logic signed [23:0]  sample;
    logic [25:0]         period;
    logic                period_valid;
    logic                locked;
    logic                overflow;

    logic                en8;
    logic                valid8;
    logic signed [23:0]  sample8;
    logic [7:0]          period8;
    logic                pv8;
    logic                locked8;
    logic                ovf8;

    typedef struct {
        bit ovf;
        int per;
        bit lck;
        int at;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    saw_period_meter u_dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .sample       (sample),
        .sample_valid (sample_valid),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked),
        .overflow     (overflow)
    );

    saw_period_meter #(.PERIOD_W(8)) u_dut8 (
        .clk          (clk),
        .rst          (rst),
        .en           (en8),
        .sample       (sample8),
        .sample_valid (valid8),
        .period       (period8),
        .period_valid (pv8),
        .locked       (locked8),
        .overflow     (ovf8)
    );

    task automatic check(input string name, input longint act, input longint req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic signed [23:0] saw_val(input int p, input int ph);
        longint v;
        v = -AMP + (2 * AMP * longint'(ph)) / longint'(p);
        return v[23:0];
    endfunction

    task automatic expect_a(input int per, input bit lck);
        exp_t e;
        e.ovf = 1'b0; e.per = per; e.lck = lck; e.at = cyc + 1;
        q_a.push_back(e);
    endtask

    task automatic expect_b(input bit ovf, input int per, input bit lck);
        exp_t e;
        e.ovf = ovf; e.per = per; e.lck = lck; e.at = cyc + 1;
        q_b.push_back(e);
    endtask

    task automatic send(input logic signed [23:0] s, input logic v);
        sample       = s;
        sample_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic send8(input logic signed [23:0] s, input logic v);
        sample8 = s;
        valid8  = v;
        @(posedge clk);
        #1;
    endtask

    // Emits phases ph0..ph1 of a saw with period setting p; phase 0 is the
    // wrap sample, which closes the previous cycle.
    task automatic saw_cycle(input int p, input int ph0, input int ph1, input bit stride2,
                             input bit pulse, input int per, input bit lck);
        for (int ph = ph0; ph <= ph1; ph++) begin
            if (ph == 0 && pulse) expect_a(per, lck);
            send(saw_val(p, ph), 1'b1);
            if (stride2) send(24'sd0, 1'b0);
        end
    endtask

    always @(negedge clk) begin
        if (period_valid || overflow) begin
            check("a_pv_ovf_exclusive", longint'(period_valid & overflow), 0);
            if (q_a.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL a_unexpected_pulse: got pv=%0b ovf=%0b period=%0d at cycle %0d, required no pulse",
                         period_valid, overflow, period, cyc);
            end else begin
                exp_t e;
                e = q_a.pop_front();
                check("a_pulse_kind_ovf", longint'(overflow), longint'(e.ovf));
                check("a_pulse_cycle", longint'(cyc), longint'(e.at));
                check("a_period", longint'(period), longint'(e.per));
                check("a_locked", longint'(locked), longint'(e.lck));
            end
        end
    end

    always @(negedge clk) begin
        if (pv8 || ovf8) begin
            check("b_pv_ovf_exclusive", longint'(pv8 & ovf8), 0);
            if (q_b.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL b_unexpected_pulse: got pv=%0b ovf=%0b period=%0d at cycle %0d, required no pulse",
                         pv8, ovf8, period8, cyc);
            end else begin
                exp_t e;
                e = q_b.pop_front();
                check("b_pulse_kind_ovf", longint'(ovf8), longint'(e.ovf));
                check("b_pulse_cycle", longint'(cyc), longint'(e.at));
                check("b_period", longint'(period8), longint'(e.per));
                check("b_locked", longint'(locked8), longint'(e.lck));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; en = 1'b0; sample = '0; sample_valid = 1'b0;
        en8 = 1'b0; sample8 = '0; valid8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_period", longint'(period), 0);
        check("rst_period_valid", longint'(period_valid), 0);
        check("rst_locked", longint'(locked), 0);
        check("rst_overflow", longint'(overflow), 0);
        check("rst_period8", longint'(period8), 0);

        rst = 1'b0; en = 1'b1; en8 = 1'b1;
        send(24'sd0, 1'b0);
        send(24'sd0, 1'b0);

        // Narrow counter: publish period 1, then saturate on constant 0.
        send8(24'sh400000, 1'b1);
        send8(24'sd0, 1'b1);
        send8(24'sh400000, 1'b1);
        expect_b(1'b0, 1, 1'b0);
        send8(24'sd0, 1'b1);
        repeat (254) send8(24'sd0, 1'b1);
        expect_b(1'b1, 1, 1'b0);
        send8(24'sd0, 1'b1);
        send8(24'sd0, 1'b0);
        send8(24'sd0, 1'b0);
        check("b_state_seek_after_ovf", longint'(u_dut8.state_q == ST_SEEK), 1);
        check("b_period_kept_after_ovf", longint'(period8), 1);
        check("b_locked_after_ovf", longint'(locked8), 0);
        // Wrap arriving with a saturated count publishes instead of overflowing.
        send8(24'sh400000, 1'b1);
        send8(24'sd0, 1'b1);
        repeat (254) send8(24'sh400000, 1'b1);
        expect_b(1'b0, 254, 1'b0);
        send8(24'sd0, 1'b1);
        send8(24'sd0, 1'b0);
        send8(24'sd0, 1'b0);

        // Ideal saw, period 99, valid every cycle.
        saw_cycle(99, 0, 99, 1'b0, 1'b0, 0, 1'b0);
        saw_cycle(99, 0, 99, 1'b0, 1'b0, 0, 1'b0);
        saw_cycle(99, 0, 99, 1'b0, 1'b1, 99, 1'b0);
        saw_cycle(99, 0, 99, 1'b0, 1'b1, 99, 1'b1);
        saw_cycle(99, 0, 99, 1'b0, 1'b1, 99, 1'b1);

        en = 1'b0;
        repeat (3) send(24'sd0, 1'b0);
        check("idle_locked_cleared", longint'(locked), 0);
        check("idle_period_kept", longint'(period), 99);

        // Same saw with sample_valid every other cycle.
        en = 1'b1;
        send(24'sd0, 1'b0);
        saw_cycle(99, 0, 99, 1'b1, 1'b0, 0, 1'b0);
        saw_cycle(99, 0, 99, 1'b1, 1'b0, 0, 1'b0);
        saw_cycle(99, 0, 99, 1'b1, 1'b1, 99, 1'b0);
        saw_cycle(99, 0, 99, 1'b1, 1'b1, 99, 1'b1);

        // Period setting switched 99 -> 49 part way through a cycle.
        saw_cycle(99, 0, 99, 1'b0, 1'b1, 99, 1'b1);
        saw_cycle(99, 0, 70, 1'b0, 1'b1, 99, 1'b1);
        saw_cycle(49, 0, 49, 1'b0, 1'b1, 70, 1'b0);
        saw_cycle(49, 0, 49, 1'b0, 1'b1, 49, 1'b0);
        saw_cycle(49, 0, 10, 1'b0, 1'b1, 49, 1'b1);

        // en dropped 10 samples into MEASURE, then re-raised.
        en = 1'b0;
        repeat (3) send(24'sd0, 1'b0);
        check("en_drop_locked", longint'(locked), 0);
        en = 1'b1;
        send(24'sd0, 1'b0);
        saw_cycle(49, 11, 49, 1'b0, 1'b0, 0, 1'b0);
        saw_cycle(49, 0, 49, 1'b0, 1'b0, 0, 1'b0);
        saw_cycle(49, 0, 49, 1'b0, 1'b1, 49, 1'b0);
        check("reen_locked_after_first", longint'(locked), 0);
        saw_cycle(49, 0, 0, 1'b0, 1'b1, 49, 1'b1);

        // Asynchronous reset while the wrap pulse is pending.
        saw_cycle(49, 1, 20, 1'b0, 1'b0, 0, 1'b0);
        send(saw_val(49, 0), 1'b1);
        #1 rst = 1'b1;
        #1;
        check("arst_period", longint'(period), 0);
        check("arst_period_valid", longint'(period_valid), 0);
        check("arst_locked", longint'(locked), 0);
        check("arst_overflow", longint'(overflow), 0);
        sample_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        saw_cycle(49, 0, 49, 1'b0, 1'b0, 0, 1'b0);
        saw_cycle(49, 0, 49, 1'b0, 1'b0, 0, 1'b0);
        saw_cycle(49, 0, 0, 1'b0, 1'b1, 49, 1'b0);
        repeat (5) send(24'sd0, 1'b0);

        check("a_queue_drained", longint'(q_a.size()), 0);
        check("b_queue_drained", longint'(q_b.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
